// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register (valid/ready) carrying a data bundle
// and a control bundle between two pipeline stages.
// - SKID=1: two entries (output register plus skid register); in_ready is a
//   flop, which breaks the combinational ready path back to the upstream stage.
// - SKID=0: one entry; in_ready is combinational.
// The control bundle is held at zero whenever out_valid is low, so a bubble
// can never carry a stale reg_write/jal bit. The data bundle keeps its last
// value during bubbles so the datapath does not toggle. A flush kills every
// held beat and any beat accepted in the same cycle.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // EMPTY: nothing held; MAIN: one beat in the output register;
    // SKID_FULL: output register plus skid register both hold a beat.
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        MAIN      = 2'd1,
        SKID_FULL = 2'd2
    } state_t;

    localparam logic [1:0] OCC_MAX = (SKID != 0) ? 2'd2 : 2'd1;

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] main_data_reg;
    logic [DATA_W-1:0] main_data_next;
    logic [CTRL_W-1:0] main_ctrl_reg;
    logic [CTRL_W-1:0] main_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg;
    logic [DATA_W-1:0] skid_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg;
    logic [CTRL_W-1:0] skid_ctrl_next;
    logic              accept;
    logic              consume;

    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_data_reg;
    assign out_ctrl  = main_ctrl_reg;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Ready generation: registered for the skid build, combinational otherwise.
    // Both are forced low while reset is held.
    generate
        if (SKID != 0) begin : g_skid_ready
            logic ready_reg;

            // in_ready flop: high unless the skid entry will be occupied next cycle.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    ready_reg <= 1'b1;
                end else begin
                    ready_reg <= (state_next != SKID_FULL);
                end
            end

            assign in_ready = ready_reg & reset;
        end else begin : g_comb_ready
            assign in_ready = reset & (~out_valid | out_ready);
        end
    endgenerate

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        main_ctrl_next = main_ctrl_reg;
        skid_data_next = skid_data_reg;
        skid_ctrl_next = skid_ctrl_reg;

        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next     = MAIN;
                    main_data_next = in_data;
                    main_ctrl_next = in_ctrl;
                end
            end
            MAIN: begin
                if (consume && accept) begin
                    main_data_next = in_data;
                    main_ctrl_next = in_ctrl;
                end else if (consume) begin
                    // Going empty: clear control, keep data to avoid toggling.
                    state_next     = EMPTY;
                    main_ctrl_next = '0;
                end else if (accept && (SKID != 0)) begin
                    // Output is stalled; park the new beat in the skid entry.
                    state_next     = SKID_FULL;
                    skid_data_next = in_data;
                    skid_ctrl_next = in_ctrl;
                end
            end
            SKID_FULL: begin
                if (consume) begin
                    // Older skid beat advances so FIFO order is preserved.
                    state_next     = MAIN;
                    main_data_next = skid_data_reg;
                    main_ctrl_next = skid_ctrl_reg;
                    skid_ctrl_next = '0;
                end
            end
            default: begin
                state_next     = EMPTY;
                main_ctrl_next = '0;
                skid_ctrl_next = '0;
            end
        endcase

        if (flush) begin
            // Drop every held and incoming beat; data keeps its last value.
            state_next     = EMPTY;
            main_data_next = main_data_reg;
            main_ctrl_next = '0;
            skid_ctrl_next = '0;
        end
    end

    // State register with asynchronous clear of everything held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_ctrl_reg <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            main_ctrl_reg <= main_ctrl_next;
            skid_data_reg <= skid_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
        end
    end

    // Occupancy is the number of held beats, decoded from the state.
    always_comb begin
        occupancy = 2'd0;
        case (state_reg)
            EMPTY:     occupancy = 2'd0;
            MAIN:      occupancy = 2'd1;
            SKID_FULL: occupancy = 2'd2;
            default:   occupancy = 2'd0;
        endcase
    end

    // Invariants: no control on bubbles, bounded occupancy, stable stalled beat.
    a_ctrl_zero_on_bubble: assert property (@(posedge clock) disable iff (!reset)
        !out_valid |-> (out_ctrl == '0));

    a_occupancy_bound: assert property (@(posedge clock) disable iff (!reset)
        occupancy <= OCC_MAX);

    a_stall_stable: assert property (@(posedge clock) disable iff (!reset)
        (out_valid && !out_ready && !flush) |=> ($stable(out_data) && $stable(out_ctrl)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance, each followed
// by a queue-based reference model compared on every falling clock edge,
// plus directed sequences with hand-computed literal expectations.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [95:0] d;
        logic [7:0]  c;
    } beat_t;

    logic        clk;
    logic        reset;

    logic        in_valid1, in_ready1, flush1, out_valid1, out_ready1;
    logic [95:0] in_data1, out_data1;
    logic [7:0]  in_ctrl1, out_ctrl1;
    logic [1:0]  occupancy1;

    logic        in_valid0, in_ready0, flush0, out_valid0, out_ready0;
    logic [95:0] in_data0, out_data0;
    logic [7:0]  in_ctrl0, out_ctrl0;
    logic [1:0]  occupancy0;

    int tests = 0;
    int fails = 0;

    beat_t       q1[$];
    beat_t       q0[$];
    logic [95:0] last1, last0;
    logic [95:0] got1[$];
    logic [95:0] got0[$];
    int          n1, n0;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1)) dut (
        .clock(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_ctrl(in_ctrl1),
        .flush(flush1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_ctrl(out_ctrl1),
        .occupancy(occupancy1)
    );

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(0)) dut0 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
        .flush(flush0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .occupancy(occupancy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model, SKID=1: a FIFO of capacity 2.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q1.delete();
            last1 <= '0;
        end else begin
            n1 = q1.size();
            if (n1 > 0 && out_ready1) void'(q1.pop_front());
            if (in_valid1 && n1 < 2) q1.push_back({in_data1, in_ctrl1});
            if (flush1) q1.delete();
            if (q1.size() > 0) last1 <= q1[0].d;
        end
    end

    // Reference model, SKID=0: a FIFO of capacity 1 that may refill while draining.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q0.delete();
            last0 <= '0;
        end else begin
            n0 = q0.size();
            if (n0 > 0 && out_ready0) void'(q0.pop_front());
            if (in_valid0 && (n0 == 0 || out_ready0)) q0.push_back({in_data0, in_ctrl0});
            if (flush0) q0.delete();
            if (q0.size() > 0) last0 <= q0[0].d;
        end
    end

    // Per-cycle comparison of both instances against the model; also logs consumed beats.
    always @(negedge clk) begin
        logic [7:0] ec;
        ec = 8'h00;
        if (q1.size() > 0) ec = q1[0].c;
        check("s1_out_valid", 96'(out_valid1), 96'(q1.size() > 0));
        check("s1_out_data",  out_data1, last1);
        check("s1_out_ctrl",  96'(out_ctrl1), 96'(ec));
        check("s1_occupancy", 96'(occupancy1), 96'(q1.size()));
        check("s1_in_ready",  96'(in_ready1), 96'(reset && q1.size() < 2));
        ec = 8'h00;
        if (q0.size() > 0) ec = q0[0].c;
        check("s0_out_valid", 96'(out_valid0), 96'(q0.size() > 0));
        check("s0_out_data",  out_data0, last0);
        check("s0_out_ctrl",  96'(out_ctrl0), 96'(ec));
        check("s0_occupancy", 96'(occupancy0), 96'(q0.size()));
        check("s0_in_ready",  96'(in_ready0), 96'(reset && (q0.size() == 0 || out_ready0)));
        if (reset && out_valid1 && out_ready1) got1.push_back(out_data1);
        if (reset && out_valid0 && out_ready0) got0.push_back(out_data0);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        in_valid1 = 1'b1; in_data1 = 96'h55; in_ctrl1 = 8'h0F; flush1 = 1'b0; out_ready1 = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0;     in_ctrl0 = 8'h00; flush0 = 1'b0; out_ready0 = 1'b0;

        // Reset held with in_valid high: nothing accepted, in_ready low.
        repeat (3) step();
        check("rst_in_ready", 96'(in_ready1), 96'd0);
        check("rst_out_valid", 96'(out_valid1), 96'd0);
        check("rst_out_ctrl", 96'(out_ctrl1), 96'd0);
        check("rst_out_data", out_data1, 96'd0);

        // Release mid-cycle: in_ready high immediately; first beat one cycle after accept.
        got1.delete();
        #2 reset = 1'b1;
        #1;
        check("rel_in_ready", 96'(in_ready1), 96'd1);
        out_ready1 = 1'b1;
        step();
        check("first_beat_valid", 96'(out_valid1), 96'd1);
        check("first_beat_data", out_data1, 96'h55);

        // Streaming 1..8 with no bubbles.
        for (int i = 1; i <= 8; i++) begin
            in_data1 = 96'(i);
            step();
            check("stream_data", out_data1, 96'(i));
            check("stream_occ", 96'(occupancy1), 96'd1);
        end
        in_valid1 = 1'b0;
        step();
        check("stream_drain_occ", 96'(occupancy1), 96'd0);
        check("stream_drain_ctrl", 96'(out_ctrl1), 96'd0);
        check("stream_hold_data", out_data1, 96'd8);
        check("stream_count", 96'(got1.size()), 96'd9);
        if (got1.size() == 9) begin
            check("stream_order0", got1[0], 96'h55);
            for (int i = 1; i <= 8; i++) check("stream_order", got1[i], 96'(i));
        end

        // Backpressure: A and B held, C refused, then drained in order.
        got1.delete();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 96'hA; in_ctrl1 = 8'h3C;
        step();
        in_data1 = 96'hB;
        step();
        check("bp_occ", 96'(occupancy1), 96'd2);
        check("bp_in_ready", 96'(in_ready1), 96'd0);
        check("bp_data_a", out_data1, 96'hA);
        in_data1 = 96'hC;
        step();
        check("bp_stall_data", out_data1, 96'hA);
        check("bp_stall_ctrl", 96'(out_ctrl1), 96'h3C);
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        step();
        check("bp_data_b", out_data1, 96'hB);
        step();
        check("bp_empty", 96'(out_valid1), 96'd0);
        check("bp_count", 96'(got1.size()), 96'd2);
        if (got1.size() == 2) begin
            check("bp_first", got1[0], 96'hA);
            check("bp_second", got1[1], 96'hB);
        end

        // Bubble control clear: ctrl FF/00 in lockstep with out_valid.
        in_ctrl1 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            in_valid1 = (i % 2 == 0);
            in_data1 = 96'(8'h70 + i);
            step();
            check("bub_ctrl", 96'(out_ctrl1), (i % 2 == 0) ? 96'hFF : 96'h0);
            check("bub_valid", 96'(out_valid1), (i % 2 == 0) ? 96'd1 : 96'd0);
        end

        // Flush with two held beats and an incoming beat C.
        got1.delete();
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_ctrl1 = 8'h11; in_data1 = 96'hA2;
        step();
        in_data1 = 96'hB2;
        step();
        check("fl_pre_occ", 96'(occupancy1), 96'd2);
        in_data1 = 96'hC2; flush1 = 1'b1;
        step();
        check("fl_occ", 96'(occupancy1), 96'd0);
        check("fl_valid", 96'(out_valid1), 96'd0);
        check("fl_ctrl", 96'(out_ctrl1), 96'd0);
        check("fl_in_ready", 96'(in_ready1), 96'd1);
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        step();
        step();
        check("fl_no_c", 96'(out_valid1), 96'd0);
        check("fl_none_out", 96'(got1.size()), 96'd0);

        // Flush with a same-cycle consume (counts) and accept (discarded).
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 96'hD2;
        step();
        in_data1 = 96'hE2; flush1 = 1'b1; out_ready1 = 1'b1;
        step();
        check("fl2_occ", 96'(occupancy1), 96'd0);
        check("fl2_hold_data", out_data1, 96'hD2);
        flush1 = 1'b0; in_valid1 = 1'b0;
        step();
        check("fl2_no_e", 96'(out_valid1), 96'd0);
        check("fl2_consumed", 96'(got1.size()), 96'd1);
        if (got1.size() == 1) check("fl2_consumed_d", got1[0], 96'hD2);

        // Asynchronous reset mid-transfer clears outputs without a clock edge.
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 96'h31;
        step();
        in_data1 = 96'h32;
        step();
        in_valid1 = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 96'(out_valid1), 96'd0);
        check("arst_occ", 96'(occupancy1), 96'd0);
        check("arst_in_ready", 96'(in_ready1), 96'd0);
        check("arst_data", out_data1, 96'd0);
        step();
        #2 reset = 1'b1;
        step();
        check("arst_rel_ready", 96'(in_ready1), 96'd1);
        check("arst_rel_valid", 96'(out_valid1), 96'd0);

        // SKID=0: combinational in_ready, single entry, full throughput.
        got0.delete();
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 96'h21; in_ctrl0 = 8'h05;
        step();
        check("s0_stall_ready", 96'(in_ready0), 96'd0);
        check("s0_first_data", out_data0, 96'h21);
        in_data0 = 96'h22;
        step();
        check("s0_stall_hold", out_data0, 96'h21);
        check("s0_stall_occ", 96'(occupancy0), 96'd1);
        out_ready0 = 1'b1; in_data0 = 96'h41;
        #1;
        check("s0_same_cycle_ready", 96'(in_ready0), 96'd1);
        for (int i = 1; i <= 6; i++) begin
            in_data0 = 96'(8'h40 + i);
            step();
            check("s0_stream_data", out_data0, 96'(8'h40 + i));
            check("s0_stream_occ", 96'(occupancy0), 96'd1);
        end
        in_valid0 = 1'b0;
        step();
        check("s0_drain", 96'(out_valid0), 96'd0);
        check("s0_count", 96'(got0.size()), 96'd7);
        if (got0.size() == 7) begin
            check("s0_order0", got0[0], 96'h21);
            for (int i = 1; i <= 6; i++) check("s0_order", got0[i], 96'(8'h40 + i));
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic replacement for the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data bundle plus a control bundle between two stages using a valid/ready handshake.
- Supports synchronous flush and bubble insertion, and has an optional skid entry that registers the upstream ready path.
- Control fields are zeroed on every bubble, so a downstream stage never sees a stale reg_write or jal bit.

Parameters:
DATA_W, 96, width of datapath bundle (e.g. next_pc, alu_out, mem_out)
CTRL_W, 8, width of control bundle (e.g. write_reg, reg_src, reg_write, jal); zeroed on bubble/flush
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream stage presents a beat
in_ready  output  1  stage can accept a beat this cycle
in_data  input  DATA_W  upstream data bundle
in_ctrl  input  CTRL_W  upstream control bundle
flush  input  1  synchronous kill of all held and incoming beats
out_valid  output  1  out_data/out_ctrl hold a valid beat
out_ready  input  1  downstream stage consumes the beat
out_data  output  DATA_W  registered data bundle
out_ctrl  output  CTRL_W  registered control bundle; 0 whenever out_valid=0
occupancy  output  2  number of beats held (0..2; max 1 when SKID=0)

Behaviour:
- Accept = in_valid & in_ready. Consume = out_valid & out_ready. All state updates happen on the rising edge of clock.
- Reset (reset=0, asynchronous):
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid entry empty.
  - in_ready=0 while reset is asserted.
  - After release: in_ready=1 on the first cycle.
- States: EMPTY (occ 0), MAIN (occ 1, beat in output register), SKID_FULL (occ 2, second beat in skid register; SKID=1 only).
- EMPTY:
  - Accept -> MAIN.
  - Beat appears at the outputs the next cycle (latency 1).
- MAIN:
  - Consume & accept -> MAIN, with the new beat loaded into the output register.
  - Consume only -> EMPTY.
  - Accept only -> SKID_FULL (SKID=1); with SKID=0 this case is impossible.
- SKID_FULL:
  - Consume -> MAIN; the skid beat moves to the output register.
  - in_ready=0, so no accept can occur.
- in_ready:
  - SKID=1: registered; equals !(skid entry full).
  - SKID=0: combinational; equals !out_valid | out_ready.
- Ordering: strict FIFO. A skid beat is always presented before any later beat.
- Stall (out_valid=1, out_ready=0): out_data and out_ctrl hold stable, bit-exact, for every stalled cycle.
- Bubble (out_valid=0):
  - out_ctrl=0.
  - out_data holds its last value, to avoid datapath toggling.
- Flush (flush=1 at an edge), highest priority:
  - Next cycle: out_valid=0, out_ctrl=0, skid entry empty, occupancy=0.
  - A beat accepted in the same cycle as flush is discarded. in_ready is not gated by flush.
  - A consume in the same cycle as flush still counts downstream (the beat was already visible).
- Simultaneous accept and consume never changes occupancy.
- Reset mid-transfer: all held beats are lost and outputs clear immediately (asynchronous), without waiting for an edge.
- No arithmetic. occupancy is a 2-bit count; it never exceeds 2, or 1 when SKID=0.

Test Plan:
- Reset/idle: hold reset=0 with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=0. Release reset -> in_ready=1 (SKID=1) and the first beat appears 1 cycle after accept.
- Streaming: out_ready=1 and beats D=1..8 on consecutive cycles -> out_data=1..8 on consecutive cycles, no bubbles, occupancy=1 throughout.
- Backpressure (SKID=1): drive beats A and B, hold out_ready=0 -> occupancy=2, in_ready=0, out_data=A stable. Raise out_ready -> A then B, in order.
- Bubble control clear: in_ctrl=8'hFF with in_valid pulsed every other cycle -> out_ctrl alternates FF/00 in lockstep with out_valid.
- Flush: with occupancy=2 plus an incoming beat C, assert flush for 1 cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0; C never appears.
- SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 in the same cycle, and full throughput is maintained.
